// File: rtl/mdu.sv
`timescale 1ns/1ps
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at start; the result commits to HI/LO on the final busy edge only.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MdOp,
  input  logic        Start,
  input  logic        WeHiLo,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;

  // Result datapath: evaluated from the latched operands, only sampled on the commit edge.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, den, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed division runs on magnitudes, so 0x80000000 / -1 needs no overflow special case.
  assign a_neg = (op_q == OP_DIV) && a_q[31];
  assign b_neg = (op_q == OP_DIV) && b_q[31];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;
  assign den   = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / den;
  assign r_mag = abs_a % den;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_hi = rem;
    res_lo = quot;
    res_we = (b_q != 32'd0);
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      // NOTE: operand latches are not reset; they are always loaded before the result is used.
    end else begin
      case (state)
        IDLE: begin
          if (Start && !MdOp[2]) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= MdOp;
            cnt   <= MdOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            Busy  <= 1'b1;
            state <= RUN;
          end else if (WeHiLo) begin
            if (MdOp == OP_MTHI) HI <= A;
            if (MdOp == OP_MTLO) LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            Busy  <= 1'b0;
            state <= IDLE;
            if (res_we) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage of the MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- The pipeline controller stalls mfhi/mflo and any new MD instruction while `Start` or `Busy` is high.
- The block latches its operands at start, so the pipeline may change `A`/`B` while it computes.

Parameters:
- MULT_CYCLES, 5, number of cycles `Busy` stays high for mult/multu.
- DIV_CYCLES, 10, number of cycles `Busy` stays high for div/divu.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- MdOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
- Start  input  1  one-cycle strobe; qualifies `MdOp` 0-3
- WeHiLo  input  1  one-cycle strobe; qualifies `MdOp` 4-5
- Busy  output  1  high while an operation is in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset:
  - Sampled at a clk edge. Sets `HI`=0, `LO`=0, `Busy`=0, cycle counter=0, and drops any pending result.
  - Reset dominates every other input on the same edge.
- States: IDLE, RUN.
- IDLE:
  - On an edge with `Start`=1 and `MdOp`<=3: latch `A`, `B` and `MdOp` into internal regs.
  - Load the counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), then go to RUN.
  - `Busy` rises in the cycle after the start edge.
- RUN:
  - The counter decrements every edge.
  - On the edge where the counter reaches 0: commit the result to `HI`/`LO`, drop `Busy` to 0 and return to IDLE.
  - With the default parameters, `Busy` is high for exactly 5 (mult) or 10 (div) cycles.
  - New `HI`/`LO` are visible in the first cycle with `Busy`=0.
- Start while busy:
  - `Start` during RUN is ignored; the controller is required never to do this.
  - `Start` with `MdOp`>=4 is ignored.
- mthi/mtlo:
  - In IDLE, `WeHiLo`=1 with `MdOp`=4 writes `HI`<=`A`; with `MdOp`=5 it writes `LO`<=`A`.
  - The write is visible the next cycle; `Busy` is not asserted.
  - `WeHiLo` during RUN is ignored.
  - If `Start` and `WeHiLo` are high on the same edge, `Start` wins and `WeHiLo` is dropped.
- Arithmetic:
  - mult: signed 32x32 gives a 64-bit product; `HI`=[63:32], `LO`=[31:0].
  - multu: unsigned 32x32, same split.
  - div: `LO`=quotient truncated toward zero; `HI`=remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `LO`=0x80000000, `HI`=0.
  - divu: unsigned quotient in `LO`, remainder in `HI`.
  - Divisor 0 (div or divu): runs the full DIV_CYCLES with `Busy` high, then leaves `HI`/`LO` unchanged.
- Result timing:
  - The result may be computed combinationally from the latched operands or iteratively.
  - Only the commit edge may change `HI`/`LO`; intermediate values must never appear on `HI`/`LO`.
- Reset mid-operation: the operation is aborted, with no late commit after reset is released.
- Outputs `HI`, `LO` and `Busy` are registered; no combinational path from any input to any output.

Test Plan:
- mult `A`=0xFFFFFFFE, `B`=3, `Start` for 1 cycle -> `Busy`=1 for exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA. Same operands with multu -> `HI`=0x00000002, `LO`=0xFFFFFFFA.
- div `A`=0xFFFFFFF9 (-7), `B`=2 -> `Busy` for 10 cycles, then `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. divu `A`=7, `B`=2 -> `LO`=3, `HI`=1. div 0x80000000 / 0xFFFFFFFF -> `LO`=0x80000000, `HI`=0.
- Preload `HI`=0x11111111, `LO`=0x22222222 via mthi/mtlo, then divu by `B`=0 -> `Busy` for 10 cycles, `HI`/`LO` still 0x11111111 / 0x22222222 afterwards.
- Start a mult, then change `A`/`B` and pulse `Start` (div) and `WeHiLo` (mthi) during RUN -> both ignored; the result equals the original mult and `Busy` falls after 5 cycles.
- Start a div, assert `reset` in busy cycle 4 -> next cycle `Busy`=0, `HI`=`LO`=0; hold 20 more cycles with no change.
- mthi `A`=0x12345678, next cycle mtlo `A`=0x9ABCDEF0 -> `HI` and `LO` update one cycle after each strobe, `Busy` never asserts. `Start` and `WeHiLo` on the same edge -> only the MD operation executes.
